fulladder_pipe_nbit: RTL and testbench



---
 rtl/fulladder_pipe_nbit.sv | 126 ++++++++++++
 tb/tb_fulladder_pipe_nbit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fulladder_pipe_nbit.sv
// fulladder_pipe_nbit: pipelined ripple-carry adder, one SEG_WIDTH-bit segment per stage.
// Optional macro FULLADDER_PIPE_OVF_EN adds the signed-overflow output ovf.

module fulladder_pipe_nbit_seg #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
endmodule

module fulladder_pipe_nbit #(
  parameter int WIDTH     = 32,
  parameter int SEG_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef FULLADDER_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int NUM_SEG = WIDTH / SEG_WIDTH;
  localparam int STAGES  = NUM_SEG - 1;

  logic            adv;
  logic [STAGES:0] vld_pipe;

  // Single global advance: the whole pipe moves or the whole pipe holds.
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[STAGES];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)   vld_pipe <= '0;
    else if (adv) vld_pipe <= (vld_pipe << 1) | (STAGES+1)'(in_valid & in_ready);

  // Operand skew: g_skew[k] holds the still-unsummed upper operand bits after stage k.
  for (genvar k = 0; k < STAGES; k++) begin : g_skew
    localparam int OW = WIDTH - (k+1)*SEG_WIDTH;
    logic [OW-1:0] ah_d, bh_d, ah_q, bh_q;

    if (k == 0) begin : g_src
      assign ah_d = a[WIDTH-1:SEG_WIDTH];
      assign bh_d = b[WIDTH-1:SEG_WIDTH];
    end else begin : g_src
      assign ah_d = g_skew[k-1].ah_q[OW+SEG_WIDTH-1:SEG_WIDTH];
      assign bh_d = g_skew[k-1].bh_q[OW+SEG_WIDTH-1:SEG_WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        ah_q <= '0;
        bh_q <= '0;
      end else if (adv) begin
        ah_q <= ah_d;
        bh_q <= bh_d;
      end
  end

  // Segment adders; each stage's sum register grows by one segment, which deskews the result.
  for (genvar k = 0; k < NUM_SEG; k++) begin : g_stage
    localparam int SW = (k+1)*SEG_WIDTH;
    logic [SEG_WIDTH-1:0] sa, sb, ss;
    logic                 ci, co;
    logic [SW-1:0]        s_d, s_q;
    logic                 c_q;

    if (k == 0) begin : g_src
      assign sa  = a[SEG_WIDTH-1:0];
      assign sb  = b[SEG_WIDTH-1:0];
      assign ci  = cin;
      assign s_d = ss;
    end else begin : g_src
      assign sa  = g_skew[k-1].ah_q[SEG_WIDTH-1:0];
      assign sb  = g_skew[k-1].bh_q[SEG_WIDTH-1:0];
      assign ci  = g_stage[k-1].c_q;
      assign s_d = {ss, g_stage[k-1].s_q};
    end

    fulladder_pipe_nbit_seg #(.W(SEG_WIDTH)) u_seg (
      .a (sa),
      .b (sb),
      .ci(ci),
      .s (ss),
      .co(co)
    );

    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        s_q <= '0;
        c_q <= 1'b0;
      end else if (adv) begin
        s_q <= s_d;
        c_q <= co;
      end
  end

  assign sum  = g_stage[STAGES].s_q;
  assign cout = g_stage[STAGES].c_q;

`ifdef FULLADDER_PIPE_OVF_EN
  // Operand sign bits are the MSBs of the top segment, so no extra sign delay is needed.
  logic ovf_d;
  assign ovf_d = (g_stage[STAGES].sa[SEG_WIDTH-1] == g_stage[STAGES].sb[SEG_WIDTH-1]) &
                 (g_stage[STAGES].ss[SEG_WIDTH-1] != g_stage[STAGES].sa[SEG_WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)   ovf <= 1'b0;
    else if (adv) ovf <= ovf_d;
`endif

endmodule

// File: tb/tb_fulladder_pipe_nbit.sv
// Bench for fulladder_pipe_nbit (32-bit, 8-bit segments): directed table, random traffic, reset cases.
// Optional macro FULLADDER_PIPE_OVF_EN enables the ovf checks.

module tb_fulladder_pipe_nbit;
  localparam int WIDTH = 32, SEG_WIDTH = 8, LAT = 4;

  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1, cin = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        in_ready, out_valid, cout;
  logic [31:0] sum;
`ifdef FULLADDER_PIPE_OVF_EN
  logic        ovf;
`endif

  fulladder_pipe_nbit #(.WIDTH(WIDTH), .SEG_WIDTH(SEG_WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout)
`ifdef FULLADDER_PIPE_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] a, b; logic cin; logic [31:0] s; logic co; logic ov; } vec_t;
  typedef struct { logic [31:0] s; logic co; logic ov; } res_t;

  res_t        exp_q[$];
  int          nvec = 0, nerr = 0, nres = 0;
  logic        ov_s, ir_s, co_s, acc_s;
  logic [31:0] sum_s;
`ifdef FULLADDER_PIPE_OVF_EN
  logic        ovf_s;
`endif

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Reference: plain 33-bit arithmetic.
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic c);
    res_t        r;
    logic [32:0] t;
    t    = {1'b0, x} + {1'b0, y} + {32'd0, c};
    r.s  = t[31:0];
    r.co = t[32];
    r.ov = (x[31] == y[31]) && (t[31] != x[31]);
    return r;
  endfunction

  // One clock: snapshot at negedge, score handshakes, then step to just past the next posedge.
  task automatic cyc();
    res_t e;
    @(negedge clk);
    ov_s  = out_valid;
    ir_s  = in_ready;
    sum_s = sum;
    co_s  = cout;
    acc_s = rst_n && in_valid && in_ready;
`ifdef FULLADDER_PIPE_OVF_EN
    ovf_s = ovf;
`endif
    if (rst_n) begin
      if (out_valid && out_ready) begin
        nres++;
        chk("result_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sb_sum", sum, e.s);
          chk("sb_cout", cout, e.co);
`ifdef FULLADDER_PIPE_OVF_EN
          chk("sb_ovf", ovf, e.ov);
`endif
        end
      end
      if (acc_s) exp_q.push_back(model(a, b, cin));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    a = v.a; b = v.b; cin = v.cin; in_valid = 1'b1; out_ready = 1'b1;
    cyc();
    chk({nm, "_accept"}, acc_s, 1);
    in_valid = 1'b0; a = $urandom; b = $urandom;
    for (int i = 1; i <= LAT; i++) begin
      cyc();
      chk({nm, "_out_valid"}, ov_s, (i == LAT) ? 1 : 0);
    end
    chk({nm, "_sum"}, sum_s, v.s);
    chk({nm, "_cout"}, co_s, v.co);
`ifdef FULLADDER_PIPE_OVF_EN
    chk({nm, "_ovf"}, ovf_s, v.ov);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[10];
    int          base, nacc;
    logic [31:0] prev_sum;

    tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    tbl[1] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    tbl[2] = '{32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0, 1'b0};
    tbl[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    tbl[4] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    tbl[5] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0, 1'b0};
    tbl[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    tbl[7] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
    tbl[8] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1};
    tbl[9] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};

    // Reset held with a valid op on the inputs.
    rst_n = 1'b0; in_valid = 1'b1; a = 32'hFFFF_FFFF; b = 32'h0; cin = 1'b1;
    repeat (3) cyc();
    chk("rst_out_valid", ov_s, 0);
    chk("rst_sum", sum_s, 0);
    chk("rst_cout", co_s, 0);
    rst_n = 1'b1;
    chk("rst_in_ready", in_ready, 1);

    // First op after release is the full carry chain.
    run_vec(tbl[0], "carry_chain");
    for (int i = 1; i < 10; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Back-to-back random, one result per clock.
    base = nres; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
      cyc();
    end
    chk("b2b_mid_count", nres - base, 96);
    in_valid = 1'b0;
    repeat (LAT) cyc();
    chk("b2b_total", nres - base, 100);
    chk("b2b_drained", exp_q.size(), 0);

    // Backpressure: consumer stalls while the producer keeps issuing.
    base = nres; nacc = 0; prev_sum = '0;
    out_ready = 1'b0; in_valid = 1'b1; a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (i >= 4) begin
        chk("bp_in_ready", ir_s, 0);
        chk("bp_out_valid", ov_s, 1);
      end
      if (i == 5) chk("bp_sum_stable", sum_s, prev_sum);
      prev_sum = sum_s;
      if (acc_s) begin
        nacc++;
        a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
      end
    end
    chk("bp_accepts", nacc, 4);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) cyc();
    chk("bp_results", nres - base, 4);
    chk("bp_drained", exp_q.size(), 0);

    // Random mixed traffic with random stalls.
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 7);
      a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (LAT + 2) cyc();
    chk("mix_drained", exp_q.size(), 0);

    // Reset with three ops in flight, oldest already at the output.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    out_ready = 1'b0;
    chk("mf_pending", exp_q.size(), 3);
    chk("mf_pre_out_valid", out_valid, 1);
    base = nres;
    #2 rst_n = 1'b0;
    #1;
    chk("mf_out_valid", out_valid, 0);
    chk("mf_sum", sum, 0);
    chk("mf_cout", cout, 0);
    exp_q.delete();
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (2) cyc();
    rst_n = 1'b1; in_valid = 1'b0;
    chk("mf_in_ready", in_ready, 1);
    repeat (8) cyc();
    chk("mf_no_results", nres - base, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
